count_requester: RTL and testbench

Initiator-side sequencer for the go/done bit-count core (the `fsm` plus datapath pair). It accepts operands on a valid/ready input stream and drives the core's `go`/`in` pins with one pulse per job. It waits for the core's `done`, captures `out`, and returns the result on a valid/ready output stream. It sits between the system's operand source and the core, so the core's level-style `done` is hidden behind stream handshakes.

---
 rtl/count_req_pkg.sv | 18 +
 rtl/req_timer.sv | 36 +++
 rtl/count_requester.sv | 124 ++++++++++++
 tb/tb_count_requester.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/count_req_pkg.sv
// Shared types and constants for the count_requester sequencer.
//   state_t            : sequencer state encoding (IDLE, ISSUE, SETTLE, WAIT, HOLD)
//   JOBS_W             : width of the consumed-result counter
//   TIMEOUT_CYCLES_DEF : default WAIT budget, used only with CORE_TIMEOUT_EN
package count_req_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    SETTLE = 3'd2,
    WAIT   = 3'd3,
    HOLD   = 3'd4
  } state_t;

  localparam int JOBS_W             = 16;
  localparam int TIMEOUT_CYCLES_DEF = 1024;

endpackage

// File: rtl/req_timer.sv
// Load/decrement/expire down-counter bounding the WAIT state.
// Instantiated by count_requester only when CORE_TIMEOUT_EN is defined.
//   clk       : clock
//   rst       : synchronous active-high reset, clears the count
//   load_i    : load CYCLES-1 (asserted the cycle before WAIT is entered)
//   dec_i     : decrement by one, saturating at zero
//   expired_o : count has reached zero
module req_timer #(
  parameter int CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic dec_i,
  output logic expired_o
);

  localparam int TW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [TW-1:0] LOAD_VAL = TW'(CYCLES - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                     cnt_d = LOAD_VAL;
    else if (dec_i && cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/count_requester.sv
// Initiator-side sequencer for the go/done bit-count core. Takes one operand
// per input handshake, pulses core_go once, waits for core_done, captures
// core_out and presents it on the result stream until consumed.
// Optional feature macro: CORE_TIMEOUT_EN (bounds WAIT to TIMEOUT_CYCLES and
// returns res_err=1 with res_data=0 on expiry).
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : operand stream handshake, in_data operand
//   res_valid/res_ready   : result stream handshake, res_data/res_err payload
//   core_go, core_in      : start pulse and held operand to the core
//   core_done, core_out   : core completion level and result
//   jobs                  : results consumed (wrapping)
module count_requester
  import count_req_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WIDTH-1:0]  res_data,
  output logic              res_err,
  output logic              core_go,
  output logic [WIDTH-1:0]  core_in,
  input  logic              core_done,
  input  logic [WIDTH-1:0]  core_out,
  output logic [JOBS_W-1:0] jobs
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("count_requester: TIMEOUT_CYCLES must be at least 1");
  end

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   op_q, op_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               err_q, err_d;
  logic [JOBS_W-1:0]  jobs_q, jobs_d;
  logic               rst_q;
  logic               tmr_expired;

`ifdef CORE_TIMEOUT_EN
  // Loaded while in SETTLE so the first WAIT cycle sees TIMEOUT_CYCLES-1.
  req_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (state_q == SETTLE),
    .dec_i     (state_q == WAIT),
    .expired_o (tmr_expired)
  );
`else
  assign tmr_expired = 1'b0;
`endif

  // Outputs decode registered state only; rst_q keeps in_ready low through
  // the reset window even though the state is already IDLE.
  assign in_ready  = (state_q == IDLE) && !rst_q;
  assign core_go   = (state_q == ISSUE);
  assign res_valid = (state_q == HOLD);
  assign res_data  = res_q;
  assign res_err   = err_q;
  assign core_in   = op_q;
  assign jobs      = jobs_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    res_d   = res_q;
    err_d   = err_q;
    jobs_d  = jobs_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          op_d    = in_data;
          state_d = ISSUE;
        end
      end
      ISSUE:  state_d = SETTLE;
      // core_done may still be the previous job's level here; not sampled.
      SETTLE: state_d = WAIT;
      WAIT: begin
        // A real done in the expiry cycle wins over the timeout.
        if (core_done) begin
          res_d   = core_out;
          err_d   = 1'b0;
          state_d = HOLD;
        end else if (tmr_expired) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) begin
          jobs_d  = jobs_q + JOBS_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      jobs_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      res_q   <= res_d;
      err_q   <= err_d;
      jobs_q  <= jobs_d;
    end
  end

endmodule

// File: tb/tb_count_requester.sv
module tb_count_requester;

`ifdef CORE_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, res_valid, res_ready, res_err;
  logic [7:0]  in_data, res_data, core_in, core_out;
  logic        core_go, core_done;
  logic [15:0] jobs;

  int n_pass = 0;
  int n_tot  = 0;
  int n_fail = 0;
  int exp_jobs = 0;

  // core behaviour knobs, set by the stimulus before each job
  int core_lat   = 1;
  bit core_stale = 1'b0;
  bit core_kill  = 1'b0;

  always #5 clk = ~clk;

  count_requester #(.WIDTH(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .core_go(core_go), .core_in(core_in), .core_done(core_done), .core_out(core_out),
    .jobs(jobs)
  );

  function automatic logic [7:0] ref_pop(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return 8'(n);
  endfunction

  // Behavioural bit-count core: done drops after go (optionally one cycle
  // late to model a stale level), rises core_lat cycles later with popcount.
  int         c_cnt;
  bit         c_hold;
  logic [7:0] c_op;
  always @(posedge clk) begin
    if (rst) begin
      core_done <= 1'b0; core_out <= 8'h00; c_cnt <= 0; c_hold <= 1'b0; c_op <= 8'h00;
    end else if (core_go) begin
      c_op <= core_in; c_hold <= core_stale; c_cnt <= core_lat;
      if (!core_stale) core_done <= 1'b0;
    end else if (c_hold) begin
      c_hold <= 1'b0; core_done <= 1'b0;
    end else if (c_cnt > 0) begin
      c_cnt <= c_cnt - 1;
      if (c_cnt == 1 && !core_kill) begin
        core_done <= 1'b1; core_out <= ref_pop(c_op);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_job(input logic [7:0] d, input int lat, input bit stale,
                         input int bp, input bit exp_to);
    int k, extra, bad, exp_lat;
    bit seen;
    logic [7:0] exp_res;
    exp_res = exp_to ? 8'h00 : ref_pop(d);
    exp_lat = exp_to ? 3 + TO : 3 + lat + int'(stale);
    core_lat = lat; core_stale = stale; core_kill = exp_to;
    k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    chk("ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = d;
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'($urandom);
    chk("go_pulse", 32'(core_go), 32'd1);
    chk("core_in", 32'(core_in), 32'(d));
    chk("busy_ready", 32'(in_ready), 32'd0);
    k = 1; seen = 1'b0; extra = 0;
    while (!seen && k < exp_lat + 20) begin
      @(negedge clk); k++;
      if (res_valid) seen = 1'b1;
      else if (core_go) extra++;
    end
    chk("go_once", 32'(extra), 32'd0);
    chk("latency", 32'(k), 32'(exp_lat));
    chk("res_data", 32'(res_data), 32'(exp_res));
    chk("res_err", 32'(res_err), 32'(exp_to));
    // new operand offered while the result is held must not be taken
    in_valid = 1'b1; in_data = ~d;
    bad = 0;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== exp_res || res_err !== exp_to ||
          core_go !== 1'b0 || in_ready !== 1'b0 || core_in !== d) bad++;
    end
    chk("hold_stable", 32'(bad), 32'd0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0; in_valid = 1'b0;
    exp_jobs = (exp_jobs + 1) & 16'hFFFF;
    chk("jobs", 32'(jobs), 32'(exp_jobs));
    chk("ready_after", 32'(in_ready), 32'd1);
    chk("valid_drop", 32'(res_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    bit stale;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_res_err", 32'(res_err), 32'd0);
    chk("rst_core_go", 32'(core_go), 32'd0);
    chk("rst_core_in", 32'(core_in), 32'd0);
    chk("rst_jobs", 32'(jobs), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    // reset while waiting on a slow core
    core_lat = 8; core_stale = 1'b0; core_kill = 1'b0;
    in_valid = 1'b1; in_data = 8'hA7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_jobs", 32'(jobs), 32'd0);
    chk("mid_rst_core_in", 32'(core_in), 32'd0);
    chk("mid_rst_go", 32'(core_go), 32'd0);
    exp_jobs = 0;
    repeat (2) @(negedge clk);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    run_job(8'h0F, 1, 1'b0, 0, 1'b0);

    // directed cases
    run_job(8'hB5, 1, 1'b0, 0, 1'b0);
    run_job(8'hFF, 1, 1'b0, 1, 1'b0);
    run_job(8'h01, 1, 1'b1, 0, 1'b0);   // done still high through SETTLE
    run_job(8'h00, 1, 1'b0, 0, 1'b0);
    run_job(8'h3C, 2, 1'b0, 10, 1'b0);

`ifdef CORE_TIMEOUT_EN
    run_job(8'h5A, 1, 1'b0, 3, 1'b1);
    run_job(8'hF0, TO, 1'b0, 0, 1'b0);  // done lands in the expiry cycle
`endif

    // randomized jobs
    for (int j = 0; j < 16; j++) begin
      stale = 1'($urandom_range(0, 1));
      run_job(8'($urandom), int'($urandom_range(1, 5)), stale,
              int'($urandom_range(0, 4)), 1'b0);
      k = int'($urandom_range(0, 3));
      repeat (k) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
